// File: rtl/pmt_req_sequencer_pkg.sv
// Shared types and helpers for the request sequencer: FSM states, index width
// derivation and the lowest-set-bit priority rule.
package pmt_req_sequencer_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Two's-complement trick isolates the lowest set bit of v.
  function automatic logic [MAX_WIDTH-1:0] lowest_set(input logic [MAX_WIDTH-1:0] v);
    return v & (~v + MAX_WIDTH'(1));
  endfunction

endpackage

// File: rtl/pmt_req_sequencer_onehot_enc.sv
// One-hot to binary encoder; output is only meaningful for a one-hot or zero input.
module onehot_enc
  import pmt_req_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int IDX_WIDTH  = idx_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] onehot,
  output logic [IDX_WIDTH-1:0]  idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (onehot[i]) begin
        idx = idx | IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/pmt_req_sequencer.sv
// Latches a request vector and serves its bits lowest-index-first, one grant
// per valid/ready handshake, pulsing o_pmtFinish once the vector is exhausted.
module pmt_req_sequencer
  import pmt_req_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int IDX_WIDTH  = idx_width(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_req,
  input  logic                  i_flush,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_grant,
  output logic [IDX_WIDTH-1:0]  o_idx,
  output logic                  o_last,
  output logic                  o_busy,
  output logic [IDX_WIDTH:0]    o_cnt,
  output logic                  o_pmtFinish
);

  state_t                state;
  logic [DATA_WIDTH-1:0] pending;
  logic [IDX_WIDTH:0]    cnt;
  logic [MAX_WIDTH-1:0]  low_wide;
  logic [DATA_WIDTH-1:0] low_bit;
  logic                  is_last;

  assign low_wide = lowest_set(MAX_WIDTH'(pending));
  assign low_bit  = low_wide[DATA_WIDTH-1:0];
  assign is_last  = (low_bit == pending);

  generate
    if (DATA_WIDTH < MAX_WIDTH) begin : g_sink
      logic unused_hi;
      assign unused_hi = ^low_wide[MAX_WIDTH-1:DATA_WIDTH];
    end
  endgenerate

  // Outputs decode only registered state and pending, never i_ready or i_req.
  assign o_valid     = (state == ISSUE);
  assign o_grant     = o_valid ? low_bit : '0;
  assign o_last      = o_valid && is_last;
  assign o_busy      = (state != IDLE);
  assign o_pmtFinish = (state == DONE);
  assign o_cnt       = cnt;

  onehot_enc #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_enc (
    .onehot(o_grant),
    .idx   (o_idx)
  );

  // Flush wins over a same-cycle handshake, so that grant is neither retired nor counted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      pending <= '0;
      cnt     <= '0;
    end else if (i_flush && state != IDLE) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            cnt <= '0;
            if (|i_req) begin
              pending <= i_req;
              state   <= ISSUE;
            end else begin
              state <= DONE;
            end
          end
        end
        ISSUE: begin
          if (i_ready) begin
            pending <= pending & ~low_bit;
            cnt     <= cnt + (IDX_WIDTH + 1)'(1);
            if (is_last) begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmt_req_sequencer.sv
// Randomized and directed bench for pmt_req_sequencer against a queue-based
// model of the pending request indices.
module tb_pmt_req_sequencer;

  localparam int DW = 5;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] req;
  logic          flush;
  logic          ready;
  logic          valid;
  logic [DW-1:0] grant;
  logic [IW-1:0] idx;
  logic          last;
  logic          busy;
  logic [IW:0]   cnt;
  logic          finish;

  int compared   = 0;
  int mismatched = 0;

  // Model: indices still to be served (ascending), a finish-pending flag, and the count.
  int q[$];
  bit m_finishing = 1'b0;
  int m_cnt       = 0;

  always #5 clk = ~clk;

  pmt_req_sequencer #(.DATA_WIDTH(DW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_req      (req),
    .i_flush    (flush),
    .i_ready    (ready),
    .o_valid    (valid),
    .o_grant    (grant),
    .o_idx      (idx),
    .o_last     (last),
    .o_busy     (busy),
    .o_cnt      (cnt),
    .o_pmtFinish(finish)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit f, input bit s, input logic [DW-1:0] v, input bit rd);
    bit m_busy;
    m_busy = (q.size() > 0) || m_finishing;
    if (r) begin
      q.delete();
      m_finishing = 1'b0;
      m_cnt = 0;
    end else if (f && m_busy) begin
      q.delete();
      m_finishing = 1'b0;
    end else if (m_finishing) begin
      m_finishing = 1'b0;
    end else if (q.size() > 0) begin
      if (rd) begin
        void'(q.pop_front());
        m_cnt++;
        if (q.size() == 0) m_finishing = 1'b1;
      end
    end else if (s) begin
      m_cnt = 0;
      for (int i = 0; i < DW; i++) if (v[i]) q.push_back(i);
      if (q.size() == 0) m_finishing = 1'b1;
    end
  endtask

  task automatic compareAll();
    bit          e_valid;
    logic [31:0] e_grant;
    logic [31:0] e_idx;
    e_valid = (q.size() > 0);
    e_grant = e_valid ? (32'd1 << q[0]) : 32'd0;
    e_idx   = e_valid ? 32'(q[0]) : 32'd0;
    checkOutput("valid",  32'(valid),  32'(e_valid));
    checkOutput("grant",  32'(grant),  e_grant);
    checkOutput("idx",    32'(idx),    e_idx);
    checkOutput("last",   32'(last),   32'(e_valid && q.size() == 1));
    checkOutput("busy",   32'(busy),   32'(e_valid || m_finishing));
    checkOutput("cnt",    32'(cnt),    32'(m_cnt));
    checkOutput("finish", 32'(finish), 32'(m_finishing));
  endtask

  // Drive one cycle of inputs, advance the model, then check just after the edge.
  task automatic applyStimulus(input bit r, input bit f, input bit s, input logic [DW-1:0] v, input bit rd);
    rst   = r;
    flush = f;
    start = s;
    req   = v;
    ready = rd;
    modelStep(r, f, s, v, rd);
    @(posedge clk);
    #1;
    compareAll();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; req = '0; flush = 1'b0; ready = 1'b0;
    applyStimulus(1, 0, 0, 5'b00000, 0);
    applyStimulus(1, 0, 0, 5'b00000, 0);

    // Full-speed batch of three grants.
    applyStimulus(0, 0, 1, 5'b10110, 1);
    checkOutput("plan1_grant0", 32'(grant), 32'b00010);
    repeat (3) applyStimulus(0, 0, 0, 5'b00000, 1);
    checkOutput("plan1_finish", 32'(finish), 32'd1);
    checkOutput("plan1_cnt", 32'(cnt), 32'd3);
    applyStimulus(0, 0, 0, 5'b00000, 1);

    // Back-pressure holds the first grant for two cycles.
    applyStimulus(0, 0, 1, 5'b10110, 0);
    applyStimulus(0, 0, 0, 5'b00000, 0);
    checkOutput("hold_grant", 32'(grant), 32'b00010);
    checkOutput("hold_idx", 32'(idx), 32'd1);
    repeat (4) applyStimulus(0, 0, 0, 5'b00000, 1);

    // Empty batch finishes immediately without grants.
    applyStimulus(0, 0, 1, 5'b00000, 1);
    checkOutput("empty_finish", 32'(finish), 32'd1);
    checkOutput("empty_cnt", 32'(cnt), 32'd0);
    applyStimulus(0, 0, 0, 5'b00000, 1);

    // A start during ISSUE is ignored.
    applyStimulus(0, 0, 1, 5'b11111, 1);
    applyStimulus(0, 0, 1, 5'b00001, 1);
    repeat (4) applyStimulus(0, 0, 0, 5'b00000, 1);
    checkOutput("full_cnt", 32'(cnt), 32'd5);
    applyStimulus(0, 0, 0, 5'b00000, 1);

    // Flush beats a same-cycle handshake.
    applyStimulus(0, 0, 1, 5'b01011, 1);
    applyStimulus(0, 0, 0, 5'b00000, 1);
    applyStimulus(0, 1, 0, 5'b00000, 1);
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_cnt", 32'(cnt), 32'd1);

    // Reset mid-batch, then a fresh batch.
    applyStimulus(0, 0, 1, 5'b11010, 0);
    applyStimulus(1, 0, 0, 5'b00000, 1);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    applyStimulus(0, 0, 1, 5'b00101, 1);
    repeat (3) applyStimulus(0, 0, 0, 5'b00000, 1);

    for (int n = 0; n < 2000; n++) begin
      logic [DW-1:0] v;
      v = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom_range(0, 31));
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
                    $urandom_range(0, 99) < 40, v, $urandom_range(0, 99) < 70);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pmt_req_sequencer.md
# pmt_req_sequencer

Sequential consumer of the lowest-index-first priority rule. It latches a request vector, issues one one-hot grant at a time over a valid/ready handshake, and retires each served bit. It pulses completion when the vector is exhausted. It sits between a request source (scheduler, PE array controller) and a single shared resource that must serve requests serially.

## Interface
- DATA_WIDTH, 5, number of request lines (≥2)
- IDX_WIDTH, $clog2(DATA_WIDTH), derived; width of grant index
- i_clk  input  1  clock; all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_start  input  1  load request: sampled only in IDLE
- i_req  input  DATA_WIDTH  request vector, sampled on accepted i_start
- i_flush  input  1  synchronous abort of current batch
- i_ready  input  1  downstream accepts current grant
- o_valid  output  1  grant valid
- o_grant  output  DATA_WIDTH  one-hot grant (lowest set pending bit); 0 when !o_valid
- o_idx  output  IDX_WIDTH  binary index of o_grant
- o_last  output  1  current grant is the final pending bit
- o_busy  output  1  batch in progress (state ≠ IDLE)
- o_cnt  output  IDX_WIDTH+1  grants handshaken in current batch
- o_pmtFinish  output  1  one-cycle pulse: batch fully served

## Operation
- Reset values: state IDLE, pending=0, o_cnt=0; o_valid, o_grant, o_idx, o_last, o_busy, o_pmtFinish all 0.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - i_start & |i_req → pending←i_req, o_cnt←0, go ISSUE.
  - i_start & i_req==0 → go DONE (empty batch, no grants).
  - Otherwise stay.
- ISSUE:
  - o_valid=1.
  - o_grant = pending & (~pending+1).
  - o_idx = encode(o_grant).
  - o_last = (o_grant==pending).
  - On o_valid & i_ready: pending←pending & ~o_grant, o_cnt←o_cnt+1. If o_last, go DONE; else stay.
- DONE: o_pmtFinish=1 for exactly one cycle, o_valid=0, o_cnt holds final count, go IDLE.
- i_start outside IDLE is ignored. i_req changes after load have no effect.
- i_flush (any state ≠ IDLE):
  - Next state IDLE, pending←0.
  - No o_pmtFinish pulse. o_cnt holds.
  - i_flush has priority over a same-cycle handshake; that grant is not counted.
- Priority: i_rst > i_flush > handshake/start.
- o_cnt never exceeds DATA_WIDTH, so no wrap.

## Timing
- o_valid, o_grant, o_idx and o_last are derived only from registered state/pending; no combinational path from i_ready or i_req to outputs.
- i_start accepted at edge t → o_valid=1 in cycle t+1.
- Grant/idx/last held stable while o_valid & !i_ready.
- With i_ready held high, N set bits → N consecutive grant cycles, o_pmtFinish in cycle after last handshake. Empty-vector start → o_pmtFinish in cycle t+1.
- Earliest re-start: the cycle o_pmtFinish is asserted does not accept i_start (state DONE). The next start is accepted in the following cycle.
- i_rst asserted mid-batch → all outputs at reset values from the next cycle.

## Structure
- Shared package holds:
  - state enum (IDLE, ISSUE, DONE)
  - lowest-set-bit helper function
  - IDX_WIDTH computation
- Sub-module onehot_enc (DATA_WIDTH → IDX_WIDTH) produces o_idx.
- Main module holds the FSM, pending register and counter.

## Test plan
All with DATA_WIDTH=5.
- i_req=5'b10110, start, i_ready=1 → grants 00010, 00100, 10000 at t+1..t+3; idx 1, 2, 4; o_last only at t+3; o_pmtFinish at t+4; o_cnt=3.
- Same vector with i_ready low for t+1..t+2 → o_grant=00010, idx=1 held stable 2 cycles; remaining sequence shifted by 2.
- Start with i_req=0 → o_pmtFinish at t+1, o_valid never high, o_cnt=0.
- i_req=5'b11111, start; reassert i_start with i_req=5'b00001 at t+2 → ignored; 5 grants 00001…10000 issued, o_cnt=5.
- i_req=5'b01011; after first handshake, assert i_flush together with i_ready → IDLE next cycle, no o_pmtFinish, o_cnt=1.
- i_rst asserted during ISSUE → next cycle o_valid=0, o_busy=0, o_grant=0; subsequent start behaves as a fresh batch.
